// File: rtl/baudgen_prog.sv
// rtl/baudgen_prog.sv - programmable baud tick generator with shadowed divisor reload
// Define BAUDGEN_FRAC_EN to enable the fractional phase accumulator.
module baudgen_prog #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 8,
  parameter int DEFAULT_DIV = 1085
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clk_ena,
  input  logic              mode_rx,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              clk_out,
  output logic              cfg_err
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] div_q, div_sh, cnt;
  logic             pending;
  logic             tick, xfer, illegal;
  logic [DIV_W-1:0] pre_div, preload, wrap_val, div_clamped;

  assign tick    = (cnt == '0) && clk_ena;
  // Shadow moves to the active divisor only on a period boundary or while idle.
  assign xfer    = pending && (tick || !clk_ena);
  // While idle, preload from the shadow so an enable right after a transfer starts on the new divisor.
  assign pre_div = (pending && !clk_ena) ? div_sh : div_q;
  assign preload = mode_rx ? (pre_div - (pre_div >> 1)) : (pre_div - ONE);
  assign illegal = (div_int < MIN_DIV);
  assign div_clamped = illegal ? MIN_DIV : div_int;
  assign clk_out = tick;

`ifdef BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_sh, acc;
  logic              carry_q;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum  = {1'b0, acc} + {1'b0, frac_q};
  // A carried period is one cycle longer; the wrap point moves from div_q-1 to div_q.
  assign wrap_val = carry_q ? div_q : (div_q - ONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frac_q  <= '0;
      frac_sh <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
    end else begin
      if (div_load) frac_sh <= div_frac;
      if (xfer) frac_q <= frac_sh;
      if (!clk_ena) begin
        acc     <= '0;
        carry_q <= 1'b0;
      end else if (tick) begin
        {carry_q, acc} <= acc_sum;
      end
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign wrap_val    = div_q - ONE;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= RST_DIV;
      div_sh  <= RST_DIV;
      pending <= 1'b0;
      cnt     <= RST_DIV - ONE;
      cfg_err <= 1'b0;
    end else begin
      if (div_load) begin
        div_sh  <= div_clamped;
        pending <= 1'b1;
        cfg_err <= illegal;
      end else if (xfer) begin
        pending <= 1'b0;
      end
      if (xfer) div_q <= div_sh;
      if (!clk_ena) cnt <= preload;
      else if (cnt == wrap_val) cnt <= '0;
      else cnt <= cnt + ONE;
    end
  end

endmodule

// File: tb/tb_baudgen_prog.sv
// tb/tb_baudgen_prog.sv - directed-vector bench for baudgen_prog
module tb_baudgen_prog;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clk_ena;
  logic        mode_rx;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic        div_load;
  logic        clk_out;
  logic        cfg_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] mask;

  baudgen_prog #(.DIV_W(16), .FRAC_W(8), .DEFAULT_DIV(1085)) dut (
    .clk(clk), .rstn(rstn), .clk_ena(clk_ena), .mode_rx(mode_rx),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .clk_out(clk_out), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int d, input int f, input bit rx);
    clk_ena  = 1'b0;
    mode_rx  = rx;
    div_int  = 16'(d);
    div_frac = 8'(f);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    step();
  endtask

  // clk_ena rises in cycle 0; returns a bitmap of the cycles that ticked.
  task automatic run(input int ncyc, input int ld1, input int d1, input int ld2, input int d2,
                     output logic [63:0] m);
    m = '0;
    clk_ena = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      div_load = (c == ld1) || (c == ld2);
      div_int  = (c == ld2) ? 16'(d2) : 16'(d1);
      if (c == 3) mode_rx = ~mode_rx;
      #4;
      m[c] = clk_out;
      step();
    end
    div_load = 1'b0;
    clk_ena  = 1'b0;
  endtask

  // Entered 1 time unit into the first cycle after reset release with clk_ena high.
  task automatic check_restart(input string tag);
    int c;
    #4;
    check({tag, "_rel_cycle"}, 64'(clk_out), 64'd0);
    step();
    #4;
    check({tag, "_first_tick"}, 64'(clk_out), 64'd1);
    c = 0;
    do begin
      @(posedge clk);
      #5;
      c++;
    end while (!clk_out && c < 2000);
    check({tag, "_period"}, 64'(c), 64'd1085);
    #1;
    clk_ena = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; clk_ena = 1'b1; mode_rx = 1'b0;
    div_int = '0; div_frac = '0; div_load = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_out", 64'(clk_out), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    rstn = 1'b1;
    check_restart("por");

    set_div(4, 0, 1'b0);
    run(16, -1, 0, -1, 0, mask);
    check("tx_div4", mask, 64'h2222);

    set_div(4, 0, 1'b1);
    run(12, -1, 0, -1, 0, mask);
    check("rx_div4", mask, 64'h444);

    set_div(5, 0, 1'b1);
    run(13, -1, 0, -1, 0, mask);
    check("rx_div5", mask, 64'h1084);

    set_div(4, 8'h80, 1'b0);
    run(20, -1, 0, -1, 0, mask);
`ifdef BAUDGEN_FRAC_EN
    check("frac_half", mask, 64'h84422);
`else
    check("frac_ignored", mask, 64'h22222);
`endif

    set_div(4, 0, 1'b0);
    run(28, 6, 8, -1, 0, mask);
    check("load_c6", mask, 64'h2020222);

    set_div(4, 0, 1'b0);
    run(20, 5, 8, -1, 0, mask);
    check("load_on_tick", mask, 64'h20222);

    set_div(4, 0, 1'b0);
    run(24, 6, 8, 7, 6, mask);
    check("load_last_wins", mask, 64'h208222);

    set_div(1, 0, 1'b0);
    check("err_set", 64'(cfg_err), 64'd1);
    run(8, -1, 0, -1, 0, mask);
    check("clamp_div2", mask, 64'hAA);
    check("err_sticky", 64'(cfg_err), 64'd1);
    set_div(3, 0, 1'b0);
    check("err_clear", 64'(cfg_err), 64'd0);
    run(10, -1, 0, -1, 0, mask);
    check("tx_div3", mask, 64'h92);

    set_div(4, 0, 1'b0);
    clk_ena = 1'b1;
    for (int c = 0; c < 7; c++) begin
      div_load = (c == 5);
      div_int  = 16'd8;
      step();
    end
    div_load = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_mid_out", 64'(clk_out), 64'd0);
    step();
    rstn = 1'b1;
    check_restart("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/baudgen_prog.md
BAUDGEN_PROG -- requirements
Module: baudgen_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of integer divisor and period counter.
REQ-002 SHALL have parameter FRAC_W, default 8: width of fractional divisor and phase accumulator.
REQ-003 SHALL have parameter DEFAULT_DIV, default 1085: integer divisor after reset (125 MHz / 115200); legal range 2..2^DIV_W-1.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port clk_ena, input, 1: run enable; low holds generator in preload.
REQ-007 SHALL have port mode_rx, input, 1: 0 = TX phase (first tick after 1 cycle); 1 = RX phase (first tick at half period).
REQ-008 SHALL have port div_int, input, DIV_W: integer divisor, sampled on div_load.
REQ-009 SHALL have port div_frac, input, FRAC_W: fractional divisor in units of 2^-FRAC_W, sampled on div_load.
REQ-010 SHALL have port div_load, input, 1: single-cycle request to load div_int/div_frac.
REQ-011 SHALL have port clk_out, output, 1: one-cycle baud tick.
REQ-012 SHALL have port cfg_err, output, 1: sticky flag for an illegal divisor load.

Function
REQ-013 SHALL keep an active divisor (div_q, frac_q), a pending shadow with a pending flag, a DIV_W-bit up-counter cnt, and a FRAC_W-bit accumulator acc.
REQ-014 SHALL drive clk_out = (cnt == 0) AND clk_ena, combinationally; no other tick source.
REQ-015 While clk_ena = 0: cnt SHALL load div_q-1 if mode_rx = 0, else div_q - floor(div_q/2); acc SHALL be held at 0.
REQ-016 While clk_ena = 1: cnt SHALL increment and wrap to 0 at P-1; P = div_q+1 if the current period carries, else div_q.
REQ-017 At each tick edge, acc SHALL update to acc+frac_q mod 2^FRAC_W; the carry out SHALL select P for the period that follows.
REQ-018 With clk_ena rising in cycle k, the first tick SHALL occur in cycle k+1 (TX) or k+floor(div_q/2) (RX); later ticks SHALL be spaced by P.
REQ-019 mode_rx SHALL affect only the preload; a change while clk_ena = 1 SHALL not alter the running period.
REQ-020 div_load SHALL capture the inputs into the shadow and set pending in the next cycle; div_int < 2 SHALL be clamped to 2 and SHALL set cfg_err.
REQ-021 A legal div_load SHALL clear cfg_err.
REQ-022 Pending SHALL transfer to div_q/frac_q at the edge ending a tick cycle, or at any edge while clk_ena = 0; pending then clears.
REQ-023 div_load in the same cycle as a tick SHALL take effect at the following tick; div_load during pending SHALL overwrite the shadow (last wins).
REQ-024 Counter width SHALL be DIV_W; period div_q+1 = 2^DIV_W SHALL wrap correctly without overflow.

Reset
REQ-025 On rstn low, asynchronously: div_q = DEFAULT_DIV, frac_q = 0, pending = 0, acc = 0, cnt = DEFAULT_DIV-1, cfg_err = 0.
REQ-026 clk_out SHALL be 0 during reset and in the first cycle after release.
REQ-027 Reset mid-period SHALL discard the pending load and phase; with clk_ena held high, the first tick SHALL follow 1 cycle after release.

Configuration
REQ-028 Macro BAUDGEN_FRAC_EN defined: fractional accumulator per REQ-017.
REQ-029 Macro BAUDGEN_FRAC_EN undefined: acc and frac_q SHALL be absent, div_frac SHALL be ignored, and P SHALL always equal div_q.

Verification
REQ-030 div_int=4, frac=0, TX, clk_ena rises in cycle 0 -> ticks in cycles 1, 5, 9, 13.
REQ-031 Same stimulus with mode_rx=1 -> ticks in cycles 2, 6, 10; div_int=5 RX -> ticks in 2, 7, 12.
REQ-032 BAUDGEN_FRAC_EN, FRAC_W=8, div_int=4, div_frac=0x80, TX -> ticks in 1, 5, 10, 14, 19 (periods 4, 5 alternating).
REQ-033 Running div 4 (ticks 1, 5, 9), div_load div_int=8 in cycle 6 -> ticks 9, 17, 25; load in cycle 5 -> ticks 9, 17.
REQ-034 div_load with div_int=1 -> cfg_err=1 and period 2; then load div_int=3 -> cfg_err=0.
REQ-035 rstn low in cycle 7 of a div 4 run with pending load -> clk_out=0 immediately; after release div_q=DEFAULT_DIV and the first tick is 1 cycle later.
